fir_decim_buf: RTL and testbench

FIR_DECIM_BUF -- requirements
Module: fir_decim_buf

---
 rtl/fir_decim_buf_if.sv | 25 ++
 rtl/fir_decim_buf.sv | 119 +++++++++++
 tb/tb_fir_decim_buf.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_buf_if.sv
// Sample stream into the decimator and decimated stream out of its FIFO.
// Yin_valid has no ready: every valid sample is taken. Dout transfers on an edge where Dout_valid && Dout_ready.
interface fir_decim_buf_if;
    logic signed [15:0] Yin;
    logic               Yin_valid;
    logic signed [15:0] Dout;
    logic               Dout_valid;
    logic               Dout_ready;

    modport master (
        output Yin,
        output Yin_valid,
        input  Dout,
        input  Dout_valid,
        output Dout_ready
    );

    modport slave (
        input  Yin,
        input  Yin_valid,
        output Dout,
        output Dout_valid,
        input  Dout_ready
    );
endinterface

// File: rtl/fir_decim_buf.sv
// Integrate-and-dump decimator (DECIM samples -> one average) feeding a small output FIFO.
// Define DECIM_ROUND_EN to round half up instead of flooring the shifted sum.
module fir_decim_buf #(
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    fir_decim_buf_if.slave           strm,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Ovf,
    input  logic                     Ovf_clr,
    output logic [$clog2(DECIM)-1:0] Phase
);
    localparam int LG = $clog2(DECIM);
    localparam int AW = 16 + LG;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LG-1:0] PH_LAST = LG'(DECIM - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [1:0] rst_sync;
    logic       rst_int_n;

    logic [LG-1:0] phase_q;
    logic [LG-1:0] phase_d;
    logic          blk_done;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] rnd;
    logic signed [15:0]   result;

    logic signed [15:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [LW-1:0]      count;
    logic               full;
    logic               pop;
    logic               wr_en;
    logic               drop;

    // Assert asynchronously, release on the second clock edge so every flop leaves reset together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) phase_q <= '0;
        else            phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        if (strm.Yin_valid) begin
            if (phase_q == PH_LAST) phase_d = '0;
            else                    phase_d = phase_q + LG'(1);
        end
    end

    always_comb begin
        blk_done = strm.Yin_valid && (phase_q == PH_LAST);
    end

    assign Phase = phase_q;

    // DECIM full-scale samples fit in AW bits, so neither sum nor the rounded sum can wrap.
    assign sum = acc_q + {{LG{strm.Yin[15]}}, strm.Yin};
`ifdef DECIM_ROUND_EN
    assign rnd = sum + AW'(DECIM / 2);
`else
    assign rnd = sum;
`endif
    assign result = 16'(rnd >>> LG);

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            acc_q <= '0;
        end else if (strm.Yin_valid) begin
            if (blk_done) acc_q <= '0;
            else          acc_q <= sum;
        end
    end

    assign full  = (count == LVL_FULL);
    assign pop   = strm.Dout_valid && strm.Dout_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign wr_en = blk_done && (!full || pop);
    assign drop  = blk_done && full && !pop;

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)      count <= count + LW'(1);
            else if (pop && !wr_en) count <= count - LW'(1);
        end
    end

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n)   Ovf <= 1'b0;
        else if (drop)    Ovf <= 1'b1;
        else if (Ovf_clr) Ovf <= 1'b0;
    end

    assign strm.Dout       = mem[rd_ptr];
    assign strm.Dout_valid = (count != '0);
    assign Level           = count;
endmodule

// File: tb/tb_fir_decim_buf.sv
// Directed bench for fir_decim_buf with DECIM=4, DEPTH=4; expected values are hand-computed.
// Inputs change 1ns after each rising edge; outputs are checked at that point.
module tb_fir_decim_buf;
    logic       Clk;
    logic       Rst_n;
    logic [2:0] Level;
    logic       Ovf;
    logic       Ovf_clr;
    logic [1:0] Phase;

    int checks;
    int failures;

`ifdef DECIM_ROUND_EN
    localparam logic [15:0] EXP_NEG = 16'hFFFF;
`else
    localparam logic [15:0] EXP_NEG = 16'hFFFE;
`endif

    fir_decim_buf_if strm ();

    fir_decim_buf #(.DECIM(4), .DEPTH(4)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .strm    (strm.slave),
        .Level   (Level),
        .Ovf     (Ovf),
        .Ovf_clr (Ovf_clr),
        .Phase   (Phase)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        strm.Yin       = v;
        strm.Yin_valid = 1'b1;
        step();
        strm.Yin_valid = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] v);
        for (int i = 0; i < 4; i++) send(v);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        Rst_n           = 1'b0;
        Ovf_clr         = 1'b0;
        strm.Yin        = '0;
        strm.Yin_valid  = 1'b0;
        strm.Dout_ready = 1'b1;

        // Power-on reset and synchronized release
        #12;
        check("rst_level", 16'(Level), 16'd0);
        check("rst_dvalid", 16'(strm.Dout_valid), 16'd0);
        check("rst_ovf", 16'(Ovf), 16'd0);
        check("rst_dout", strm.Dout, 16'd0);
        step();
        Rst_n = 1'b1;
        repeat (3) step();
        check("idle_phase", 16'(Phase), 16'd0);

        // Basic average: (100+200+300+400)/4 = 250
        send(16'd100);
        send(16'd200);
        check("basic_phase2", 16'(Phase), 16'd2);
        check("basic_pre_valid", 16'(strm.Dout_valid), 16'd0);
        send(16'd300);
        send(16'd400);
        check("basic_valid", 16'(strm.Dout_valid), 16'd1);
        check("basic_dout", strm.Dout, 16'd250);
        check("basic_level", 16'(Level), 16'd1);
        step();
        check("basic_one_cycle", 16'(strm.Dout_valid), 16'd0);

        // Signed: sum -5, floor -> -2, round half up -> -1
        send(16'hFFFF);
        send(16'hFFFF);
        send(16'hFFFF);
        send(16'hFFFE);
        check("neg_valid", 16'(strm.Dout_valid), 16'd1);
        check("neg_dout", strm.Dout, EXP_NEG);
        step();

        // Gapped input: idle cycles hold accumulator and phase
        for (int i = 0; i < 3; i++) begin
            send(16'd8);
            step();
        end
        check("gap_phase", 16'(Phase), 16'd3);
        check("gap_no_early", 16'(strm.Dout_valid), 16'd0);
        send(16'd8);
        check("gap_valid", 16'(strm.Dout_valid), 16'd1);
        check("gap_dout", strm.Dout, 16'd8);
        step();
        check("gap_single", 16'(strm.Dout_valid), 16'd0);

        // Full and drop: blocks of 4k average to 4k; the fifth is dropped
        strm.Dout_ready = 1'b0;
        send_block(16'd4);
        check("fill_level1", 16'(Level), 16'd1);
        send_block(16'd8);
        send_block(16'd12);
        check("fill_stable_dout", strm.Dout, 16'd4);
        send_block(16'd16);
        check("full_level", 16'(Level), 16'd4);
        check("full_no_ovf", 16'(Ovf), 16'd0);
        send_block(16'd20);
        check("drop_level", 16'(Level), 16'd4);
        check("drop_ovf", 16'(Ovf), 16'd1);
        Ovf_clr = 1'b1;
        step();
        Ovf_clr = 1'b0;
        check("ovf_clr", 16'(Ovf), 16'd0);
        strm.Dout_ready = 1'b1;
        check("pop0", strm.Dout, 16'd4);
        step();
        check("pop1", strm.Dout, 16'd8);
        step();
        check("pop2", strm.Dout, 16'd12);
        step();
        check("pop3", strm.Dout, 16'd16);
        step();
        check("drained_level", 16'(Level), 16'd0);
        check("drained_valid", 16'(strm.Dout_valid), 16'd0);

        // Full FIFO: push and pop on the same edge
        strm.Dout_ready = 1'b0;
        send_block(16'd1);
        send_block(16'd2);
        send_block(16'd3);
        send_block(16'd4);
        check("refill_level", 16'(Level), 16'd4);
        send(16'd5);
        send(16'd5);
        send(16'd5);
        strm.Dout_ready = 1'b1;
        send(16'd5);
        strm.Dout_ready = 1'b0;
        check("pushpop_level", 16'(Level), 16'd4);
        check("pushpop_ovf", 16'(Ovf), 16'd0);
        check("pushpop_head", strm.Dout, 16'd2);

        // Overflow again, then reset mid-clock and mid-block
        send_block(16'd6);
        check("drop2_ovf", 16'(Ovf), 16'd1);
        send(16'd100);
        send(16'd100);
        #3;
        Rst_n = 1'b0;
        #1;
        check("async_rst_level", 16'(Level), 16'd0);
        check("async_rst_valid", 16'(strm.Dout_valid), 16'd0);
        check("async_rst_ovf", 16'(Ovf), 16'd0);
        check("async_rst_dout", strm.Dout, 16'd0);
        step();
        Rst_n = 1'b1;
        repeat (3) step();
        strm.Dout_ready = 1'b1;
        send_block(16'd8);
        check("post_rst_valid", 16'(strm.Dout_valid), 16'd1);
        check("post_rst_dout", strm.Dout, 16'd8);
        step();
        check("post_rst_empty", 16'(Level), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
